// File: rtl/utmi_pkg.sv
// Shared types and constants for the full-speed UTMI link controller:
// bus-ownership states, LineState encodings and default bit-timing values.
package utmi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_BUSY   = 3'd1,
        ST_RX_GAP    = 3'd2,
        ST_TX_BUSY   = 3'd3,
        ST_TX_GAP    = 3'd4,
        ST_WAIT_RESP = 3'd5
    } link_state_e;

    // LineState is {DM,DP}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    localparam int unsigned CLKS_PER_BIT_DEF = 32'd4;
    localparam int unsigned IPG_BITS_DEF     = 32'd2;
    localparam int unsigned TIMEOUT_BITS_DEF = 32'd18;

    function automatic int unsigned timer_width(input int unsigned bits, input int unsigned clks);
        return $clog2(bits * clks + 32'd1);
    endfunction

endpackage

// File: rtl/utmi_bit_timer.sv
// Bit-time down-counter used for the inter-packet gap and the response window.
// A load always wins over the decrement; the count parks at zero.
module utmi_bit_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: load, else saturating decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;
    assign zero  = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/utmi_link_ctrl.sv
// Half-duplex DP/DM ownership controller: arbitrates RX vs TX, enforces the
// inter-packet gap and times out when an expected response never arrives.
module utmi_link_ctrl
    import utmi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned IPG_BITS     = IPG_BITS_DEF,
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEF,
    parameter int unsigned CNT_W        = timer_width(TIMEOUT_BITS, CLKS_PER_BIT)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TxValid_i,
    input  logic       expect_resp_i,
    input  logic       tx_done_i,
    input  logic       RX_active_i,
    input  logic       RX_error_i,
    input  logic [1:0] LineState_i,
    output logic       TX_en,
    output logic       rx_enable_o,
    output logic       TxReady_o,
    output logic       timeout_o,
    output logic       rx_err_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] IPG_LOAD     = CNT_W'(IPG_BITS * CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_BITS * CLKS_PER_BIT);

    link_state_e      state_r, state_nxt_s;
    logic             expect_r;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic [CNT_W-1:0] count_s;
    logic             zero_s;
    logic             expire_s;

    logic tx_en_r, rx_enable_r, tx_ready_r, timeout_r, rx_err_r, busy_r;
    logic tx_en_nxt_s, rx_enable_nxt_s, tx_ready_nxt_s, timeout_nxt_s, rx_err_nxt_s, busy_nxt_s;

    utmi_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (load_s),
        .load_val (load_val_s),
        .count    (count_s),
        .zero     (zero_s)
    );

    // A timed state ends on the edge where the count reaches zero, so a load of N lasts N cycles
    assign expire_s = zero_s | (count_s == CNT_W'(1));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and timer-load decode; RX always has priority over TX and expiry
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_val_s  = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (RX_active_i) begin
                    state_nxt_s = ST_RX_BUSY;
                end else if (TxValid_i && (LineState_i == LS_J)) begin
                    state_nxt_s = ST_TX_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RX_BUSY: begin
                if (!RX_active_i) begin
                    state_nxt_s = ST_RX_GAP;
                    load_s      = 1'b1;
                    load_val_s  = IPG_LOAD;
                end else begin
                    state_nxt_s = ST_RX_BUSY;
                end
            end
            ST_RX_GAP: begin
                if (RX_active_i) begin
                    state_nxt_s = ST_RX_BUSY;
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RX_GAP;
                end
            end
            ST_TX_BUSY: begin
                if (tx_done_i) begin
                    state_nxt_s = ST_TX_GAP;
                    load_s      = 1'b1;
                    load_val_s  = IPG_LOAD;
                end else begin
                    state_nxt_s = ST_TX_BUSY;
                end
            end
            ST_TX_GAP: begin
                if (expire_s && expect_r) begin
                    state_nxt_s = ST_WAIT_RESP;
                    load_s      = 1'b1;
                    load_val_s  = TIMEOUT_LOAD;
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_TX_GAP;
                end
            end
            ST_WAIT_RESP: begin
                if (RX_active_i) begin
                    state_nxt_s = ST_RX_BUSY;
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Response-expected flag: captured at grant, dropped once the response starts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            expect_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_TX_BUSY)) begin
            expect_r <= expect_resp_i;
        end else if ((state_r == ST_WAIT_RESP) && (state_nxt_s == ST_RX_BUSY)) begin
            expect_r <= 1'b0;
        end else begin
            expect_r <= expect_r;
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with state_r
    always_comb begin
        tx_en_nxt_s     = (state_nxt_s == ST_TX_BUSY) || (state_nxt_s == ST_TX_GAP);
        rx_enable_nxt_s = (state_nxt_s == ST_IDLE)    || (state_nxt_s == ST_RX_BUSY) ||
                          (state_nxt_s == ST_RX_GAP)  || (state_nxt_s == ST_WAIT_RESP);
        tx_ready_nxt_s  = (state_r == ST_IDLE)      && (state_nxt_s == ST_TX_BUSY);
        timeout_nxt_s   = (state_r == ST_WAIT_RESP) && (state_nxt_s == ST_IDLE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        if ((state_nxt_s == ST_RX_BUSY) && (state_r != ST_RX_BUSY)) begin
            rx_err_nxt_s = 1'b0;
        end else if ((state_r == ST_RX_BUSY) && RX_error_i) begin
            rx_err_nxt_s = 1'b1;
        end else begin
            rx_err_nxt_s = rx_err_r;
        end
    end

    // Output registers; async reset drops TX_en without waiting for a clock
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_en_r     <= 1'b0;
            rx_enable_r <= 1'b1;
            tx_ready_r  <= 1'b0;
            timeout_r   <= 1'b0;
            rx_err_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            tx_en_r     <= tx_en_nxt_s;
            rx_enable_r <= rx_enable_nxt_s;
            tx_ready_r  <= tx_ready_nxt_s;
            timeout_r   <= timeout_nxt_s;
            rx_err_r    <= rx_err_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign TX_en       = tx_en_r;
    assign rx_enable_o = rx_enable_r;
    assign TxReady_o   = tx_ready_r;
    assign timeout_o   = timeout_r;
    assign rx_err_o    = rx_err_r;
    assign busy_o      = busy_r;

endmodule
